// File: rtl/matrix_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// matrix_pkg : shared sizes, op codes and sequencer states for matrix_op_ctrl
// Rev 1.0
// ----------------------------------------------------------------------------
package matrix_pkg;
    localparam int DATA_W    = 16;
    localparam int MAX_DIM   = 5;
    localparam int NUM_SLOTS = 3;
    localparam int DIM_W     = 3;
    localparam int SLOT_W    = 2;

    localparam logic [1:0] OP_ADD       = 2'b00;
    localparam logic [1:0] OP_SUB       = 2'b01;
    localparam logic [1:0] OP_TRANSPOSE = 2'b10;
    localparam logic [1:0] OP_SCALE     = 2'b11;

    typedef enum logic [3:0] {
        ST_IDLE, ST_DIM_A, ST_DIM_B, ST_CHECK, ST_RD_A,
        ST_RD_B, ST_WR, ST_DIM_WR, ST_DONE, ST_ERR
    } state_t;
endpackage
`default_nettype wire

// File: rtl/matrix_op_ctrl_idx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// matrix_idx_counter : row-major element walker over an m x n matrix
// Rev 1.0
// ----------------------------------------------------------------------------
module matrix_idx_counter
    import matrix_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             advance,
    input  logic [DIM_W-1:0] m,
    input  logic [DIM_W-1:0] n,
    output logic [DIM_W-1:0] row,
    output logic [DIM_W-1:0] col,
    output logic             last
);
    localparam logic [DIM_W-1:0] ONE = 1;

    logic [DIM_W-1:0] row_q, row_d;
    logic [DIM_W-1:0] col_q, col_d;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clear) begin
            row_d = '0;
            col_d = '0;
        end else if (advance) begin
            if (col_q == n - ONE) begin
                col_d = '0;
                row_d = row_q + ONE;
            end else begin
                col_d = col_q + ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row  = row_q;
    assign col  = col_q;
    assign last = (row_q == m - ONE) && (col_q == n - ONE);
endmodule
`default_nettype wire

// File: rtl/matrix_op_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// matrix_op_ctrl : runs one whole-matrix add/sub/transpose/scale over the store
// Rev 1.0
// ----------------------------------------------------------------------------
module matrix_op_ctrl
    import matrix_pkg::*;
#(
    parameter int DATA_W    = matrix_pkg::DATA_W,
    parameter int MAX_DIM   = matrix_pkg::MAX_DIM,
    parameter int NUM_SLOTS = matrix_pkg::NUM_SLOTS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [1:0]        src_a,
    input  logic [1:0]        src_b,
    input  logic [1:0]        dst,
    input  logic [DATA_W-1:0] scalar,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        mem_rd_slot,
    output logic [2:0]        mem_rd_row,
    output logic [2:0]        mem_rd_col,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic [2:0]        mem_cur_m,
    input  logic [2:0]        mem_cur_n,
    output logic [1:0]        mem_wr_slot,
    output logic [2:0]        mem_wr_row,
    output logic [2:0]        mem_wr_col,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic              mem_wr_we,
    output logic [2:0]        mem_res_m,
    output logic [2:0]        mem_res_n,
    output logic              mem_dim_we
);
    state_t            state_q, state_d;
    logic [1:0]        op_q, op_d, src_a_q, src_a_d, src_b_q, src_b_d, dst_q, dst_d;
    logic [DATA_W-1:0] scalar_q, scalar_d, opa_q, opa_d;
    logic [2:0]        ma_q, ma_d, na_q, na_d, mb_q, mb_d, nb_q, nb_d;
    logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [1:0]        rd_slot_q, rd_slot_d, wr_slot_q, wr_slot_d;
    logic [2:0]        wr_row_q, wr_row_d, wr_col_q, wr_col_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              wr_we_q, wr_we_d, dim_we_q, dim_we_d;
    logic [2:0]        res_m_q, res_m_d, res_n_q, res_n_d;

    logic              cnt_clear, cnt_advance, cnt_last;
    logic [2:0]        cnt_row, cnt_col;
    logic              is_addsub, is_tr, cmd_bad;
    logic [DATA_W-1:0] a_val, b_val, wr_val;

    matrix_idx_counter u_idx (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (cnt_clear),
        .advance (cnt_advance),
        .m       (ma_q),
        .n       (na_q),
        .row     (cnt_row),
        .col     (cnt_col),
        .last    (cnt_last)
    );

    assign cnt_clear   = (state_q == ST_IDLE) || (state_q == ST_CHECK);
    assign cnt_advance = (state_q == ST_WR) && !cnt_last;
    assign is_addsub   = (op_q == OP_ADD) || (op_q == OP_SUB);
    assign is_tr       = (op_q == OP_TRANSPOSE);

    assign cmd_bad = (int'(src_a_q) >= NUM_SLOTS) || (int'(dst_q) >= NUM_SLOTS)
                  || (is_addsub && (int'(src_b_q) >= NUM_SLOTS))
                  || (ma_q == 3'd0) || (int'(ma_q) > MAX_DIM)
                  || (na_q == 3'd0) || (int'(na_q) > MAX_DIM)
                  || (is_addsub && ((ma_q != mb_q) || (na_q != nb_q)))
                  || (is_tr && (dst_q == src_a_q));

    // Outputs are registered, so the element value is formed from the operand
    // being read in the cycle that hands over to WR.
    always_comb begin
        a_val = (state_q == ST_RD_A) ? mem_rd_data : opa_q;
        b_val = mem_rd_data;
        case (op_q)
            OP_ADD:       wr_val = a_val + b_val;
            OP_SUB:       wr_val = a_val - b_val;
            OP_TRANSPOSE: wr_val = a_val;
            default:      wr_val = a_val * scalar_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        src_a_d  = src_a_q;
        src_b_d  = src_b_q;
        dst_d    = dst_q;
        scalar_d = scalar_q;
        opa_d    = opa_q;
        ma_d     = ma_q;
        na_d     = na_q;
        mb_d     = mb_q;
        nb_d     = nb_q;
        case (state_q)
            ST_IDLE: if (start) begin
                op_d     = op;
                src_a_d  = src_a;
                src_b_d  = src_b;
                dst_d    = dst;
                scalar_d = scalar;
                state_d  = ST_DIM_A;
            end
            ST_DIM_A: begin
                ma_d    = mem_cur_m;
                na_d    = mem_cur_n;
                state_d = ST_DIM_B;
            end
            ST_DIM_B: begin
                mb_d    = mem_cur_m;
                nb_d    = mem_cur_n;
                state_d = ST_CHECK;
            end
            ST_CHECK: state_d = cmd_bad ? ST_ERR : ST_RD_A;
            ST_RD_A: begin
                opa_d   = mem_rd_data;
                state_d = is_addsub ? ST_RD_B : ST_WR;
            end
            ST_RD_B:   state_d = ST_WR;
            ST_WR:     state_d = cnt_last ? ST_DIM_WR : ST_RD_A;
            ST_DIM_WR: state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            ST_ERR:    state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_d == ST_DONE);
        err_d     = (state_d == ST_ERR);
        wr_we_d   = (state_d == ST_WR);
        dim_we_d  = (state_d == ST_DIM_WR);
        rd_slot_d = ((state_d == ST_DIM_B) || (state_d == ST_RD_B)) ? src_b_d : src_a_d;
        wr_slot_d = wr_slot_q;
        wr_row_d  = wr_row_q;
        wr_col_d  = wr_col_q;
        wr_data_d = wr_data_q;
        res_m_d   = res_m_q;
        res_n_d   = res_n_q;
        if (state_d == ST_WR) begin
            wr_slot_d = dst_q;
            wr_row_d  = is_tr ? cnt_col : cnt_row;
            wr_col_d  = is_tr ? cnt_row : cnt_col;
            wr_data_d = wr_val;
        end
        if (state_d == ST_DIM_WR) begin
            wr_slot_d = dst_q;
            res_m_d   = is_tr ? na_q : ma_q;
            res_n_d   = is_tr ? ma_q : na_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            src_a_q   <= '0;
            src_b_q   <= '0;
            dst_q     <= '0;
            scalar_q  <= '0;
            opa_q     <= '0;
            ma_q      <= '0;
            na_q      <= '0;
            mb_q      <= '0;
            nb_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            rd_slot_q <= '0;
            wr_slot_q <= '0;
            wr_row_q  <= '0;
            wr_col_q  <= '0;
            wr_data_q <= '0;
            wr_we_q   <= 1'b0;
            dim_we_q  <= 1'b0;
            res_m_q   <= '0;
            res_n_q   <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            src_a_q   <= src_a_d;
            src_b_q   <= src_b_d;
            dst_q     <= dst_d;
            scalar_q  <= scalar_d;
            opa_q     <= opa_d;
            ma_q      <= ma_d;
            na_q      <= na_d;
            mb_q      <= mb_d;
            nb_q      <= nb_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            rd_slot_q <= rd_slot_d;
            wr_slot_q <= wr_slot_d;
            wr_row_q  <= wr_row_d;
            wr_col_q  <= wr_col_d;
            wr_data_q <= wr_data_d;
            wr_we_q   <= wr_we_d;
            dim_we_q  <= dim_we_d;
            res_m_q   <= res_m_d;
            res_n_q   <= res_n_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign mem_rd_slot = rd_slot_q;
    assign mem_rd_row  = cnt_row;
    assign mem_rd_col  = cnt_col;
    assign mem_wr_slot = wr_slot_q;
    assign mem_wr_row  = wr_row_q;
    assign mem_wr_col  = wr_col_q;
    assign mem_wr_data = wr_data_q;
    assign mem_wr_we   = wr_we_q;
    assign mem_res_m   = res_m_q;
    assign mem_res_n   = res_n_q;
    assign mem_dim_we  = dim_we_q;
endmodule
`default_nettype wire

// File: tb/tb_matrix_op_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_matrix_op_ctrl : scoreboard bench with a matrix store and reference model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_matrix_op_ctrl;
    import matrix_pkg::*;

    localparam int EV_WR = 0, EV_DIM = 1, EV_DONE = 2, EV_ERR = 3;

    typedef struct {
        int kind; int slot; int row; int col; int data; int cyc;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n, start;
    logic [1:0]  op, src_a, src_b, dst;
    logic [15:0] scalar;
    logic        busy, done, err, mem_wr_we, mem_dim_we;
    logic [1:0]  mem_rd_slot, mem_wr_slot;
    logic [2:0]  mem_rd_row, mem_rd_col, mem_wr_row, mem_wr_col;
    logic [2:0]  mem_cur_m, mem_cur_n, mem_res_m, mem_res_n;
    logic [15:0] mem_rd_data, mem_wr_data;

    logic [15:0] mem   [0:3][0:7][0:7];
    logic [2:0]  mem_m [0:3];
    logic [2:0]  mem_n [0:3];
    logic        ld_we, ld_dim_we;
    logic [1:0]  ld_slot;
    logic [2:0]  ld_row, ld_col, ld_m, ld_n;
    logic [15:0] ld_data;

    logic [15:0] ref_mem [0:3][0:4][0:4];
    int          ref_m [0:3];
    int          ref_n [0:3];
    ev_t         exp_q [$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          busy_cnt = 0;
    logic [42:0] all_outs;

    matrix_op_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .dst(dst), .scalar(scalar),
        .busy(busy), .done(done), .err(err),
        .mem_rd_slot(mem_rd_slot), .mem_rd_row(mem_rd_row), .mem_rd_col(mem_rd_col),
        .mem_rd_data(mem_rd_data), .mem_cur_m(mem_cur_m), .mem_cur_n(mem_cur_n),
        .mem_wr_slot(mem_wr_slot), .mem_wr_row(mem_wr_row), .mem_wr_col(mem_wr_col),
        .mem_wr_data(mem_wr_data), .mem_wr_we(mem_wr_we),
        .mem_res_m(mem_res_m), .mem_res_n(mem_res_n), .mem_dim_we(mem_dim_we)
    );

    always #5 clk = ~clk;

    assign mem_rd_data = mem[mem_rd_slot][mem_rd_row][mem_rd_col];
    assign mem_cur_m   = mem_m[mem_rd_slot];
    assign mem_cur_n   = mem_n[mem_rd_slot];
    assign all_outs = {busy, done, err, mem_rd_slot, mem_rd_row, mem_rd_col,
                       mem_wr_slot, mem_wr_row, mem_wr_col, mem_wr_data, mem_wr_we,
                       mem_res_m, mem_res_n, mem_dim_we};

    always @(posedge clk) begin
        if (mem_wr_we) mem[mem_wr_slot][mem_wr_row][mem_wr_col] <= mem_wr_data;
        if (mem_dim_we) begin
            mem_m[mem_wr_slot] <= mem_res_m;
            mem_n[mem_wr_slot] <= mem_res_n;
        end
        if (ld_we) mem[ld_slot][ld_row][ld_col] <= ld_data;
        if (ld_dim_we) begin
            mem_m[ld_slot] <= ld_m;
            mem_n[ld_slot] <= ld_n;
        end
    end

    function automatic logic [63:0] pack(input int k, s, r, c, d, cy);
        return {8'(k), 8'(s), 8'(r), 8'(c), 16'(d), 16'(cy)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, expv);
    endtask

    task automatic take(input string name, input logic [63:0] act);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL %s: got unexpected event %h expected none", name, act);
        end else begin
            e = exp_q.pop_front();
            check(name, act, pack(e.kind, e.slot, e.row, e.col, e.data, e.cyc));
        end
    endtask

    // Reference: the whole result matrix is formed from the pre-command
    // contents, then the expected write stream is emitted in source order.
    task automatic predict(input logic [1:0] o, input int a, b, d, input logic [15:0] s,
                           input bit apply);
        int m, n;
        bit addsub, tr, bad;
        logic [15:0] x, y;
        logic [15:0] res [0:4][0:4];
        m      = ref_m[a];
        n      = ref_n[a];
        addsub = (o == OP_ADD) || (o == OP_SUB);
        tr     = (o == OP_TRANSPOSE);
        bad    = (a >= NUM_SLOTS) || (d >= NUM_SLOTS) || (addsub && b >= NUM_SLOTS)
              || (m < 1) || (m > MAX_DIM) || (n < 1) || (n > MAX_DIM)
              || (addsub && (m != ref_m[b] || n != ref_n[b]))
              || (tr && d == a);
        if (bad) begin
            exp_q.push_back('{EV_ERR, 0, 0, 0, 0, 4});
            return;
        end
        for (int r = 0; r < m; r++) begin
            for (int c = 0; c < n; c++) begin
                x = ref_mem[a][r][c];
                y = ref_mem[b][r][c];
                case (o)
                    OP_ADD:       res[r][c] = x + y;
                    OP_SUB:       res[r][c] = x - y;
                    OP_TRANSPOSE: res[r][c] = x;
                    default:      res[r][c] = x * s;
                endcase
                exp_q.push_back('{EV_WR, d, tr ? c : r, tr ? r : c, int'(res[r][c]), 0});
            end
        end
        exp_q.push_back('{EV_DIM, d, tr ? n : m, tr ? m : n, 0, 0});
        exp_q.push_back('{EV_DONE, 0, 0, 0, 0, 3 + (addsub ? 3 : 2) * m * n + 2});
        if (apply) begin
            for (int r = 0; r < m; r++)
                for (int c = 0; c < n; c++)
                    ref_mem[d][tr ? c : r][tr ? r : c] = res[r][c];
            ref_m[d] = tr ? n : m;
            ref_n[d] = tr ? m : n;
        end
    endtask

    task automatic set_el(input int s, r, c, input logic [15:0] v);
        @(negedge clk);
        ld_we = 1'b1; ld_dim_we = 1'b0;
        ld_slot = 2'(s); ld_row = 3'(r); ld_col = 3'(c); ld_data = v;
        ref_mem[s][r][c] = v;
    endtask

    task automatic set_dim(input int s, m, n);
        @(negedge clk);
        ld_we = 1'b0; ld_dim_we = 1'b1;
        ld_slot = 2'(s); ld_m = 3'(m); ld_n = 3'(n);
        ref_m[s] = m; ref_n[s] = n;
    endtask

    task automatic ld_end();
        @(negedge clk);
        ld_we = 1'b0; ld_dim_we = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int t = 0; t < 4000; t++) begin
            @(negedge clk);
            if (done) start = 1'b0;
            if (exp_q.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL timeout: got %0d pending events busy=%b expected 0 pending idle",
                     exp_q.size(), busy);
            exp_q.delete();
            start = 1'b0;
        end
    endtask

    task automatic issue(input logic [1:0] o, input int a, b, d, input logic [15:0] s);
        @(negedge clk);
        op = o; src_a = 2'(a); src_b = 2'(b); dst = 2'(d); scalar = s; start = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_cmd(input logic [1:0] o, input int a, b, d, input logic [15:0] s,
                           input bit hold);
        predict(o, a, b, d, s, 1'b1);
        issue(o, a, b, d, s);
        if (hold) begin
            op = ~o; src_a = 2'(a + 1); dst = 2'(d + 1); scalar = ~s;
        end else begin
            start = 1'b0;
        end
        wait_idle();
    endtask

    task automatic load_mat(input int s, m, n, input int base, step);
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                set_el(s, r, c, 16'(base + step * (r * n + c)));
        set_dim(s, m, n);
        ld_end();
    endtask

    function automatic int pick_slot();
        return ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
    endfunction

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_cnt = 0;
            end else begin
                if (busy) busy_cnt++;
                if (mem_wr_we || mem_dim_we)
                    check("we_exclusive", 64'(mem_wr_we & mem_dim_we), 64'd0);
                if (mem_wr_we)
                    take("elem_write", pack(EV_WR, int'(mem_wr_slot), int'(mem_wr_row),
                                            int'(mem_wr_col), int'(mem_wr_data), 0));
                if (mem_dim_we)
                    take("dim_write", pack(EV_DIM, int'(mem_wr_slot), int'(mem_res_m),
                                           int'(mem_res_n), 0, 0));
                if (done) begin
                    take("done_cycles", pack(EV_DONE, 0, 0, 0, 0, busy_cnt));
                    busy_cnt = 0;
                end
                if (err) begin
                    take("err_cycles", pack(EV_ERR, 0, 0, 0, 0, busy_cnt));
                    busy_cnt = 0;
                end
            end
        end
    end

    initial begin : driver
        int wr_seen;
        bit hit;
        rst_n = 1'b0; start = 1'b0; op = '0; src_a = '0; src_b = '0; dst = '0; scalar = '0;
        ld_we = 1'b0; ld_dim_we = 1'b0; ld_slot = '0; ld_row = '0; ld_col = '0;
        ld_data = '0; ld_m = '0; ld_n = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'(all_outs), 64'd0);
        rst_n = 1'b1;
        for (int s = 0; s < 4; s++) load_mat(s, 0, 0, 0, 0);

        load_mat(0, 2, 3, 1, 1);
        load_mat(1, 2, 3, 10, 0);
        run_cmd(OP_ADD, 0, 1, 2, 16'd0, 1'b0);
        check("add_r0c0", 64'(mem[2][0][0]), 64'd11);
        check("add_r1c2", 64'(mem[2][1][2]), 64'd16);
        check("add_dims", 64'({mem_m[2], mem_n[2]}), 64'({3'd2, 3'd3}));

        load_mat(0, 1, 1, 0, 0);
        load_mat(1, 1, 1, 1, 0);
        run_cmd(OP_SUB, 0, 1, 2, 16'd0, 1'b0);
        check("sub_wrap", 64'(mem[2][0][0]), 64'hFFFF);

        load_mat(0, 2, 3, 1, 1);
        run_cmd(OP_TRANSPOSE, 0, 0, 1, 16'd0, 1'b0);
        check("tr_r0c1", 64'(mem[1][0][1]), 64'd4);
        check("tr_r2c0", 64'(mem[1][2][0]), 64'd3);
        check("tr_dims", 64'({mem_m[1], mem_n[1]}), 64'({3'd3, 3'd2}));

        set_el(0, 0, 0, 16'h4000);
        set_el(0, 0, 1, 16'd3);
        set_dim(0, 1, 2);
        ld_end();
        run_cmd(OP_SCALE, 0, 0, 0, 16'd4, 1'b0);
        check("scale_ovf", 64'(mem[0][0][0]), 64'd0);
        check("scale_el1", 64'(mem[0][0][1]), 64'd12);
        check("scale_dims", 64'({mem_m[0], mem_n[0]}), 64'({3'd1, 3'd2}));

        load_mat(0, 2, 3, 1, 1);
        load_mat(1, 3, 2, 1, 1);
        load_mat(2, 0, 0, 0, 0);
        run_cmd(OP_ADD, 0, 1, 2, 16'd0, 1'b0);
        run_cmd(OP_ADD, 0, 0, 3, 16'd0, 1'b0);
        run_cmd(OP_SCALE, 2, 0, 0, 16'd2, 1'b0);
        run_cmd(OP_TRANSPOSE, 0, 0, 0, 16'd0, 1'b0);

        load_mat(0, 5, 5, 7, 3);
        load_mat(1, 5, 5, 100, 1);
        run_cmd(OP_ADD, 0, 1, 2, 16'd0, 1'b1);
        run_cmd(OP_SCALE, 2, 0, 2, 16'd3, 1'b0);

        for (int it = 0; it < 25; it++) begin
            if (it % 3 == 0) begin
                int m, n;
                m = $urandom_range(1, 5);
                n = $urandom_range(1, 5);
                for (int s = 0; s < 3; s++) begin
                    for (int r = 0; r < 5; r++)
                        for (int c = 0; c < 5; c++)
                            set_el(s, r, c, 16'($urandom));
                    if ($urandom_range(0, 3) == 0)
                        set_dim(s, $urandom_range(0, 7), $urandom_range(0, 7));
                    else
                        set_dim(s, m, n);
                end
                ld_end();
            end
            run_cmd(2'($urandom_range(0, 3)), pick_slot(), pick_slot(), pick_slot(),
                    16'($urandom), 1'b0);
        end

        load_mat(0, 3, 3, 1, 1);
        load_mat(1, 3, 3, 100, 0);
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                set_el(2, r, c, 16'h7777);
        set_dim(2, 1, 1);
        ld_end();
        predict(OP_ADD, 0, 1, 2, 16'd0, 1'b0);
        issue(OP_ADD, 0, 1, 2, 16'd0);
        start = 1'b0;
        wr_seen = 0;
        hit = 1'b0;
        for (int t = 0; t < 200; t++) begin
            if (mem_wr_we) wr_seen++;
            if (wr_seen == 4) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        check("reset_reached_wr4", 64'(hit), 64'd1);
        check("reset_abort_outs", 64'(all_outs), 64'd0);
        repeat (2) @(negedge clk);
        exp_q.delete();
        rst_n = 1'b1;
        check("abort_dims_kept", 64'({mem_m[2], mem_n[2]}), 64'({3'd1, 3'd1}));
        check("abort_el3_written", 64'(mem[2][0][2]), 64'd103);
        check("abort_el4_untouched", 64'(mem[2][1][0]), 64'h7777);
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                set_el(2, r, c, 16'h7777);
        ld_end();
        run_cmd(OP_ADD, 0, 1, 2, 16'd0, 1'b0);
        check("post_reset_add", 64'(mem[2][2][2]), 64'd109);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/matrix_op_ctrl.md
# matrix_op_ctrl

Sequencer that runs one whole-matrix operation (add, subtract, transpose, scalar scale) over the shared matrix store. It drives the store's ALU read port (asynchronous element and dimension read) and ALU write port (synchronous element and dimension write). It accepts one command at a time from the top-level UI FSM, validates slots and dimensions, walks every element, commits result dimensions last, then reports done or err.

## Interface
- DATA_W, 16, element width
- MAX_DIM, 5, largest legal m or n (row stride of the store is 5)
- NUM_SLOTS, 3, legal slot indices 0..NUM_SLOTS-1
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  command strobe; sampled only in IDLE
- op  in  2  00 ADD, 01 SUB, 10 TRANSPOSE, 11 SCALE
- src_a, src_b, dst  in  2 each  slot indices; src_b used only by ADD/SUB
- scalar  in  DATA_W  multiplier for SCALE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on success
- err  out  1  one-cycle pulse on rejected command
- mem_rd_slot  out  2; mem_rd_row, mem_rd_col  out  3 each  read address
- mem_rd_data  in  DATA_W; mem_cur_m, mem_cur_n  in  3 each  combinational read data and dims of mem_rd_slot
- mem_wr_slot  out  2; mem_wr_row, mem_wr_col  out  3 each; mem_wr_data  out  DATA_W; mem_wr_we  out  1
- mem_res_m, mem_res_n  out  3 each; mem_dim_we  out  1

## Operation
- States: IDLE, DIM_A, DIM_B, CHECK, RD_A, RD_B, WR, DIM_WR, DONE, ERR.
- IDLE: on start=1, latch op/src_a/src_b/dst/scalar → DIM_A. start while busy is ignored; the latched command is unaffected.
- DIM_A: mem_rd_slot=src_a; latch ma,na → DIM_B. DIM_B: mem_rd_slot=src_b; latch mb,nb (value unused unless ADD/SUB) → CHECK.
- CHECK → ERR if any of the following hold; otherwise clear row/col counters → RD_A.
  - any used slot ≥ NUM_SLOTS
  - ma or na is 0 or > MAX_DIM
  - ADD/SUB with (ma,na)≠(mb,nb)
  - TRANSPOSE with dst==src_a
- Iteration: row-major over source, r=0..ma-1, c=0..na-1.
- RD_A: read src_a[r][c] and latch it as opa. ADD/SUB → RD_B; otherwise → WR.
- RD_B: read src_b[r][c] and latch it as opb → WR.
- WR: mem_wr_we=1, mem_wr_slot=dst, one cycle.
  - Address: [r][c]; TRANSPOSE writes [c][r].
  - Data: ADD opa+opb; SUB opa−opb; TRANSPOSE opa; SCALE low DATA_W bits of opa*scalar. All two's-complement, modulo 2^DATA_W, no saturation.
  - Next: last element → DIM_WR; else advance c (wrap to 0 and increment r at na-1) → RD_A.
- DIM_WR: mem_dim_we=1, mem_wr_slot=dst. mem_res_m/n = (ma,na), or (na,ma) for TRANSPOSE → DONE.
- DONE: done=1 → IDLE. ERR: err=1, no memory write ever issued → IDLE.
- Aliasing: ADD/SUB/SCALE with dst equal to a source is legal; each element is read before its own write and never reread.
- mem_wr_we and mem_dim_we are never high in the same cycle and are 0 outside WR/DIM_WR.

## Timing
- Reset: state IDLE; busy, done, err, mem_wr_we, mem_dim_we = 0; all address, data and dim outputs = 0; latched command registers = 0.
- Reset mid-operation aborts immediately. Elements already written stay written; dst dims are not updated.
- Command accepted at edge k → busy high from k.
- Busy-state cycles including DONE:
  - ADD/SUB: 3 + 3·m·n + 2
  - TRANSPOSE/SCALE: 3 + 2·m·n + 2
  - Rejected command: 4 (DIM_A, DIM_B, CHECK, ERR)
- Reads are combinational within the same state cycle; operands latch at the state's closing edge.
- Element write commits at the end of the WR cycle; dims commit at the end of DIM_WR.
- start may be re-asserted on the cycle after DONE/ERR, i.e. in IDLE.

## Structure
- Shared package matrix_pkg:
  - op encoding localparams OP_ADD, OP_SUB, OP_TRANSPOSE, OP_SCALE
  - MAX_DIM, NUM_SLOTS, DATA_W
  - state encoding
- Sub-module matrix_idx_counter: nested row/col counter with clear, advance, bounds (m,n) inputs and a last flag. Instantiated once.
- Arithmetic is inline in the controller.

## Test plan
- Slot0=2×3 [1..6], slot1=2×3 all 10, ADD src_a=0 src_b=1 dst=2 → slot2 = [11..16], dims 2×3, done after 23 busy cycles, exactly 6 write strobes.
- SUB slot0 [0] minus slot1 [1], 1×1 → 0xFFFF written; TRANSPOSE 2×3 [1..6] slot0→slot1 → rows [1,4],[2,5],[3,6], dims 3×2, done after 17 cycles.
- SCALE 1×2 [0x4000,3] by 4, dst=src → [0x0000,12] in place, dims unchanged 1×2.
- Dimension mismatch (2×3 vs 3×2) ADD; dst=3; source dims 0×0; TRANSPOSE dst==src → err pulse after 4 cycles each, zero mem_wr_we/mem_dim_we.
- start held high during a 5×5 ADD with a different op → ignored; exactly one done; next start in IDLE accepted.
- rst_n low during WR of element 4 of a 3×3 ADD → all outputs 0 within the reset cycle, dst dims unchanged, next command runs normally.
